data_bus_arbiter: RTL and testbench

//  Shares the single data-memory port between the pipeline core MEM stage and a

---
 rtl/data_bus_arbiter_if.sv | 55 +++++
 rtl/data_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_data_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_if
// Bundles the three data-memory paths that meet at the arbiter:
//   core side : core_addr/core_read/core_write/core_wdata in, core_rdata/core_stall out
//   DMA side  : dma_req/dma_we/dma_addr/dma_wdata in, dma_gnt/dma_rvalid/dma_rdata out
//   RAM side  : ram_addr/ram_we/ram_wdata out, ram_rdata in (asynchronous read)
// Modports:
//   slave  - the arbiter's view (requests in, RAM port driven out)
//   master - the environment's view (core, DMA engine and RAM model)
// -----------------------------------------------------------------------------
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // core MEM-stage port
    logic [ADDR_W-1:0] core_addr;
    logic              core_read;
    logic              core_write;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    // secondary master port
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    // data RAM port
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  core_addr, core_read, core_write, core_wdata,
        output core_rdata, core_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output core_addr, core_read, core_write, core_wdata,
        input  core_rdata, core_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
// Shares one data-RAM port between the core MEM stage (static priority) and a
// secondary bus master (DMA / loader). The secondary master is served in slots
// where the core is idle; if it has waited MAX_WAIT busy cycles, the next cycle
// is a forced slot in which the core is stalled and the DMA owns the RAM.
// Ports:
//   clk_i     clock, all state on the rising edge
//   reset_ni  asynchronous active-low reset
//   bus       data_bus_arbiter_if.slave (core, DMA and RAM signal groups)
// Parameters:
//   ADDR_W, DATA_W  address / data width (must match the interface instance)
//   MAX_WAIT        busy-cycle wait before a forced slot, 1..255
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    data_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state_q;
    logic [7:0]        wait_cnt_q;
    logic              core_stall_q;
    logic              dma_rvalid_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic core_busy;
    logic grant;
    logic dma_owns;

    assign core_busy = bus.core_read | bus.core_write;

    // Grant is combinational: the access happens in the same cycle the slot
    // is available. Gating with reset_ni keeps dma_gnt low while reset is held.
    always_comb begin
        grant = 1'b0;
        if (reset_ni && bus.dma_req) begin
            case (state_q)
                ST_IDLE,
                ST_WAIT:  grant = ~core_busy;
                ST_FORCE: grant = 1'b1;
                default:  grant = 1'b0;
            endcase
        end
    end

    // In a forced slot the DMA owns the RAM even if it misbehaved and dropped
    // its request, so the stalled core can never write in that cycle.
    assign dma_owns = grant | (state_q == ST_FORCE);

    assign bus.ram_addr   = dma_owns ? bus.dma_addr  : bus.core_addr;
    assign bus.ram_wdata  = dma_owns ? bus.dma_wdata : bus.core_wdata;
    assign bus.ram_we     = dma_owns ? (grant & bus.dma_we) : bus.core_write;

    assign bus.core_rdata = bus.ram_rdata;
    assign bus.core_stall = core_stall_q;
    assign bus.dma_gnt    = grant;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.dma_rdata  = dma_rdata_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 8'd0;
            core_stall_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            // Read data is captured at the grant edge and held until the next read.
            dma_rvalid_q <= grant & ~bus.dma_we;
            if (grant && !bus.dma_we) begin
                dma_rdata_q <= bus.ram_rdata;
            end

            core_stall_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.dma_req && core_busy) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (!bus.dma_req) begin
                        // request withdrawn: abandon it quietly
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= 8'd0;
                    end else if (!core_busy) begin
                        // granted this cycle in an idle slot
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == MAX_WAIT_C) begin
                        // stall is registered so it lines up with the FORCE cycle
                        state_q      <= ST_FORCE;
                        core_stall_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ST_FORCE: begin
                    state_q    <= ST_IDLE;
                    wait_cnt_q <= 8'd0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wait_cnt_q <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
// Drives data_bus_arbiter with a behavioural core, DMA master and async-read
// RAM. A monitor keeps a reference memory image, queues expected DMA read
// data at read grants and compares it when dma_rvalid pulses.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_bus_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    // RAM model: asynchronous read, synchronous write, 64 words
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr[5:0]] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = ram[bus.ram_addr[5:0]];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // reference memory image and expected DMA read data
    logic [DW-1:0] mdl [64];
    logic [DW-1:0] sb [$];
    logic          exp_rv = 1'b0;
    int            lat    = 0;

    always @(negedge clk) begin
        if (bus.core_read && !bus.core_stall)
            chk("core_rdata", bus.core_rdata, mdl[bus.core_addr[5:0]]);
        if (reset_n) begin
            chk("dma_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, exp_rv});
            if (bus.dma_rvalid) begin
                if (sb.size() == 0) chk("rvalid_without_read", 32'd1, 32'd0);
                else                chk("dma_rdata", bus.dma_rdata, sb.pop_front());
            end
            if (bus.dma_req) begin
                if (bus.dma_gnt) begin
                    chk("dma_latency_ok", {31'b0, lat <= MAX_WAIT + 1}, 32'd1);
                    lat = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end else begin
            lat = 0;
        end
        if (bus.dma_gnt) begin
            if (bus.dma_we) mdl[bus.dma_addr[5:0]] = bus.dma_wdata;
            else            sb.push_back(mdl[bus.dma_addr[5:0]]);
        end else if (bus.core_write && !bus.core_stall) begin
            mdl[bus.core_addr[5:0]] = bus.core_wdata;
        end
        exp_rv = reset_n && bus.dma_gnt && !bus.dma_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.core_read  = rd;
        bus.core_write = wr;
        bus.core_addr  = a;
        bus.core_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = a;
        bus.dma_wdata = d;
    endtask

    initial begin
        logic g, s;
        set_core(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // Reset phase: core zero-fills the RAM (RAM follows core during reset)
        for (int i = 0; i < 64; i++) begin
            set_core(1'b0, 1'b1, 32'(i), 32'd0);
            set_dma(1'b1, 1'b1, 32'h10, 32'h55);
            @(negedge clk);
            if (i == 3) begin
                chk("rst_gnt", {31'b0, bus.dma_gnt}, 32'd0);
                chk("rst_stall", {31'b0, bus.core_stall}, 32'd0);
                chk("rst_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
                chk("rst_rdata", bus.dma_rdata, 32'd0);
                chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd1);
                chk("rst_ram_addr", bus.ram_addr, 32'd3);
            end
            step();
        end
        set_core(1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", {31'b0, bus.dma_gnt}, 32'd0);
        step();

        // 1: core idle, DMA write then back-to-back read of 0x10
        set_dma(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_wr_gnt", {31'b0, bus.dma_gnt}, 32'd1);
        chk("t1_ram_we", {31'b0, bus.ram_we}, 32'd1);
        chk("t1_ram_addr", bus.ram_addr, 32'h10);
        chk("t1_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
        step();
        bus.dma_we = 1'b0;
        @(negedge clk);
        chk("t1_rd_gnt", {31'b0, bus.dma_gnt}, 32'd1);
        chk("t1_rd_ram_we", {31'b0, bus.ram_we}, 32'd0);
        step();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
        chk("t1_rdata", bus.dma_rdata, 32'hDEADBEEF);
        chk("t1_no_gnt", {31'b0, bus.dma_gnt}, 32'd0);
        step();

        // 3: core busy 3 cycles then idle -> grant in the 4th cycle, no stall
        set_dma(1'b1, 1'b1, 32'h30, 32'h1234);
        for (int c = 0; c < 4; c++) begin
            set_core(c < 3, 1'b0, 32'h05, 32'd0);
            @(negedge clk);
            chk($sformatf("t3_gnt_c%0d", c), {31'b0, bus.dma_gnt}, {31'b0, c == 3});
            chk($sformatf("t3_stall_c%0d", c), {31'b0, bus.core_stall}, 32'd0);
            step();
        end
        bus.dma_req = 1'b0;

        // 2: core reads every cycle -> exactly one forced slot, MAX_WAIT+1 cycles after req
        set_core(1'b1, 1'b0, 32'h05, 32'd0);
        set_dma(1'b1, 1'b0, 32'h10, 32'd0);
        for (int c = 0; c <= MAX_WAIT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("t2_stall_c%0d", c), {31'b0, bus.core_stall}, {31'b0, c == MAX_WAIT + 1});
            chk($sformatf("t2_gnt_c%0d", c), {31'b0, bus.dma_gnt}, {31'b0, c == MAX_WAIT + 1});
            step();
        end
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t2_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
        chk("t2_rdata", bus.dma_rdata, 32'hDEADBEEF);
        chk("t2_no_stall_after", {31'b0, bus.core_stall}, 32'd0);
        step();

        // 4: core write 0x20<-1 collides with forced DMA write 0x20<-2
        set_core(1'b0, 1'b1, 32'h20, 32'd1);
        set_dma(1'b1, 1'b1, 32'h20, 32'd2);
        for (int c = 0; c <= MAX_WAIT + 1; c++) begin
            @(negedge clk);
            if (c == MAX_WAIT + 1) begin
                chk("t4_stall", {31'b0, bus.core_stall}, 32'd1);
                chk("t4_gnt", {31'b0, bus.dma_gnt}, 32'd1);
                chk("t4_ram_we", {31'b0, bus.ram_we}, 32'd1);
                chk("t4_ram_wdata", bus.ram_wdata, 32'd2);
            end else begin
                chk($sformatf("t4_wait_gnt_c%0d", c), {31'b0, bus.dma_gnt}, 32'd0);
            end
            step();
        end
        set_core(1'b0, 1'b0, 32'd0, 32'd0);
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t4_ram_20", ram[6'h20], 32'd2);
        step();

        // 5: reset while waiting (wait_cnt=5)
        set_core(1'b1, 1'b0, 32'h05, 32'd0);
        set_dma(1'b1, 1'b0, 32'h30, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t5_wait_gnt_c%0d", c), {31'b0, bus.dma_gnt}, 32'd0);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_gnt", {31'b0, bus.dma_gnt}, 32'd0);
        chk("t5_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("t5_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
        chk("t5_rdata", bus.dma_rdata, 32'd0);
        chk("t5_ram_we", {31'b0, bus.ram_we}, 32'd0);
        chk("t5_ram_addr", bus.ram_addr, 32'h05);
        set_core(1'b0, 1'b0, 32'd0, 32'd0);
        bus.dma_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t5_idle_gnt_c%0d", c), {31'b0, bus.dma_gnt}, 32'd0);
            chk($sformatf("t5_idle_stall_c%0d", c), {31'b0, bus.core_stall}, 32'd0);
            step();
        end
        set_dma(1'b1, 1'b0, 32'h30, 32'd0);
        @(negedge clk);
        chk("t5_new_gnt", {31'b0, bus.dma_gnt}, 32'd1);
        step();
        bus.dma_req = 1'b0;
        @(negedge clk);
        chk("t5_new_rdata", bus.dma_rdata, 32'h1234);
        step();

        // 6: random traffic, core honours stall by repeating its request
        g = 1'b0;
        s = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!s) begin
                case ($urandom_range(0, 2))
                    0:       set_core(1'b1, 1'b0, 32'($urandom_range(0, 15)), 32'd0);
                    1:       set_core(1'b0, 1'b1, 32'($urandom_range(0, 15)), $urandom);
                    default: set_core(1'b0, 1'b0, 32'd0, 32'd0);
                endcase
            end
            if (!(bus.dma_req && !g)) begin
                if ($urandom_range(0, 99) < 40)
                    set_dma(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
                else
                    bus.dma_req = 1'b0;
            end
            @(negedge clk);
            g = bus.dma_gnt;
            s = bus.core_stall;
            step();
        end
        set_core(1'b0, 1'b0, 32'd0, 32'd0);
        bus.dma_req = 1'b0;
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        for (int a = 0; a < 64; a++) begin
            chk($sformatf("ram_%0d", a), ram[a], mdl[a]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
